// File: rtl/mips_mem_checker.sv
// mips_mem_checker: scans a window of data-memory words against an expected-value port and reports done/pass/first error.
// Define MIPS_MEM_CHECKER_MASK_EN to add cmp_mask and compare only the bits it enables.
module mips_mem_checker #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4),
    parameter int NUM_WORDS = 4,
    parameter int WAIT_CYCLES = 10,
    parameter int RD_LAT = 1,
    parameter int CNT_W = 8,
    parameter int AUTO_START = 1,
    localparam int IDX_W = $clog2(NUM_WORDS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [IDX_W-1:0]  exp_idx,
    input  logic [DATA_W-1:0] exp_data,
`ifdef MIPS_MEM_CHECKER_MASK_EN
    input  logic [DATA_W-1:0] cmp_mask,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_DRAIN, S_DONE} state_t;
    localparam int WC_W = $clog2(WAIT_CYCLES + 1) + 1;
    localparam logic [WC_W-1:0] W_LAST = WC_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_WORDS - 1);
    state_t state, nxt;
    logic armed, trig, vld_d, mism, cmp_vld;
    logic [WC_W-1:0] wcnt;
    logic [ADDR_W-1:0] addr_d, cmp_addr;
`ifdef MIPS_MEM_CHECKER_MASK_EN
    assign mism = |((mem_rdata ^ exp_data) & cmp_mask);
`else
    assign mism = mem_rdata != exp_data;
`endif
    // With zero read latency the compare lines up with the strobe itself
    assign cmp_vld = RD_LAT == 0 ? mem_rd_en : vld_d;
    assign cmp_addr = RD_LAT == 0 ? mem_addr : addr_d;
    always_comb begin
        nxt = state;
        trig = (state == S_IDLE || state == S_DONE) && (start || armed);
        mem_rd_en = state == S_SCAN;
        busy = state == S_WAIT || state == S_SCAN || state == S_DRAIN;
        done = state == S_DONE;
        pass = done && err_count == '0;
        case (state)
            S_IDLE, S_DONE: if (trig) nxt = WAIT_CYCLES == 0 ? S_SCAN : S_WAIT;
            S_WAIT: if (wcnt == W_LAST) nxt = S_SCAN;
            S_SCAN: if (exp_idx == I_LAST) nxt = RD_LAT == 0 ? S_DONE : S_DRAIN;
            S_DRAIN: nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            armed <= AUTO_START != 0;
            wcnt <= '0;
            vld_d <= 1'b0;
            addr_d <= '0;
            mem_addr <= '0;
            exp_idx <= '0;
            err_count <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            state <= nxt;
            armed <= 1'b0;
            vld_d <= mem_rd_en;
            addr_d <= mem_addr;
            wcnt <= state == S_WAIT ? wcnt + WC_W'(1) : '0;
            if (nxt == S_SCAN && state != S_SCAN) begin
                mem_addr <= BASE_ADDR;
                exp_idx <= '0;
            end else if (mem_rd_en && exp_idx != I_LAST) begin
                mem_addr <= mem_addr + ADDR_STEP;
                exp_idx <= exp_idx + IDX_W'(1);
            end
            // A saturated counter never returns to zero, so zero marks the first error
            if (trig) begin
                err_count <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
            end else if (cmp_vld && mism) begin
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
                if (err_count == '0) begin
                    first_err_addr <= cmp_addr;
                    first_err_data <= mem_rdata;
                end
            end
        end
    end
endmodule
